// File: rtl/mmio_pkg.sv
// Shared types and constants for the load/store bridge: FSM states, RISC-V
// funct3 size codes, IO window geometry and the timeout read pattern.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAM_RD  = 2'd1,
        IO_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int          IO_WIN_BYTES = 16;
    localparam logic [31:0] ERR_DATA     = 32'hDEAD_BEEF;

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

    // Loads reject 011 and 11x; stores only know sb/sh/sw.
    function automatic logic bad_funct3(input logic we, input logic [2:0] f3);
        if (we) begin
            return !((f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW));
        end
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/mmio_if.sv
// Bundle of the CPU request/done, data-RAM and IO-channel signals of the bridge.
// slave = the bridge itself; master = core, RAM and peripherals around it.
interface mmio_if #(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 14,
    parameter int NUM_IO = 4
) ();
    logic                cpu_req;
    logic                cpu_we;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [2:0]          cpu_funct3;
    logic [31:0]         cpu_wdata;
    logic                cpu_done;
    logic [31:0]         cpu_rdata;
    logic                cpu_err;
    logic                cpu_busy;

    logic [RAM_AW-1:0]   ram_addr;
    logic [3:0]          ram_be;
    logic [31:0]         ram_wdata;
    logic [31:0]         ram_rdata;

    logic [NUM_IO-1:0]   io_sel;
    logic                io_we;
    logic [1:0]          io_reg;
    logic [31:0]         io_wdata;
    logic [NUM_IO*32-1:0] io_rdata;
    logic [NUM_IO-1:0]   io_ready;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_funct3, cpu_wdata,
        output cpu_done, cpu_rdata, cpu_err, cpu_busy,
        output ram_addr, ram_be, ram_wdata,
        input  ram_rdata,
        output io_sel, io_we, io_reg, io_wdata,
        input  io_rdata, io_ready
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_funct3, cpu_wdata,
        input  cpu_done, cpu_rdata, cpu_err, cpu_busy,
        input  ram_addr, ram_be, ram_wdata,
        output ram_rdata,
        input  io_sel, io_we, io_reg, io_wdata,
        output io_rdata, io_ready
    );
endinterface

// File: rtl/mmio_lane.sv
// Combinational byte-lane logic: store enables/replicated data and load
// extraction with sign/zero extension, selected by funct3 and addr[1:0].
module mmio_lane
    import mmio_pkg::*;
(
    input  logic [2:0]  f3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wlane_o,
    output logic [31:0] rext_o
);
    logic [31:0] shifted;

    always_comb begin
        shifted = rword_i >> {lane_i, 3'b000};

        case (f3_i)
            F3_SB:   begin be_o = 4'b0001 << lane_i; wlane_o = {4{wdata_i[7:0]}};  end
            F3_SH:   begin be_o = 4'b0011 << lane_i; wlane_o = {2{wdata_i[15:0]}}; end
            default: begin be_o = 4'b1111;           wlane_o = wdata_i;            end
        endcase

        case (f3_i)
            F3_LB:   rext_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  rext_o = {24'b0, shifted[7:0]};
            F3_LH:   rext_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  rext_o = {16'b0, shifted[15:0]};
            F3_LW:   rext_o = shifted;
            default: rext_o = shifted;
        endcase
    end
endmodule

// File: rtl/mmio_bridge.sv
// Load/store bridge from the execute stage to data RAM and NUM_IO IO channels; the core holds cpu_req until cpu_done.
// Latency: store/error 1 cycle, RAM load 2, IO 1 cycle after io_ready; MMIO_TIMEOUT_EN bounds the IO wait.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 32,
    parameter int          RAM_AW  = 14,
    parameter int          NUM_IO  = 4,
    parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
    parameter int          TIMEOUT = 255
) (
    input  logic  clk,
    input  logic  rst,
    mmio_if.slave bus
);
    localparam int WIN_SH = $clog2(IO_WIN_BYTES);

    if (DATA_W != 32 || NUM_IO < 1 || NUM_IO > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
        $error("mmio_bridge: unsupported parameter set");
    end

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

`ifdef MMIO_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]        cnt_q, cnt_d;
`endif

    logic              acc, io_act;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr, ch_full;
    logic [2:0]        cur_f3, ch_idx;
    logic [DATA_W-1:0] cur_wdata;
    logic              is_io, ch_ok, bad, sel_rdy;
    logic [31:0]       sel_word, rword, rext, wlane;
    logic [3:0]        be;

    // In IDLE the request is decoded straight from the core so the first
    // RAM/IO access happens in the acceptance cycle; afterwards from latches.
    assign acc       = (state_q == IDLE) && bus.cpu_req && rst;
    assign cur_we    = (state_q == IDLE) ? bus.cpu_we     : we_q;
    assign cur_addr  = (state_q == IDLE) ? bus.cpu_addr   : addr_q;
    assign cur_f3    = (state_q == IDLE) ? bus.cpu_funct3 : f3_q;
    assign cur_wdata = (state_q == IDLE) ? bus.cpu_wdata  : wdata_q;

    assign is_io   = cur_addr >= ADDR_W'(IO_BASE);
    assign ch_full = (cur_addr - ADDR_W'(IO_BASE)) >> WIN_SH;
    assign ch_ok   = ch_full < ADDR_W'(NUM_IO);
    assign ch_idx  = ch_full[2:0];
    assign bad     = bad_funct3(cur_we, cur_f3) || misaligned(cur_f3, cur_addr[1:0])
                   || (is_io && !ch_ok);

    always_comb begin
        sel_word = '0;
        sel_rdy  = 1'b0;
        for (int k = 0; k < NUM_IO; k++) begin
            if (ch_idx == 3'(k)) begin
                sel_word = bus.io_rdata[32*k +: 32];
                sel_rdy  = bus.io_ready[k];
            end
        end
    end

    assign rword = (state_q == RAM_RD) ? bus.ram_rdata : sel_word;

    mmio_lane u_lane (
        .f3_i    (cur_f3),
        .lane_i  (cur_addr[1:0]),
        .wdata_i (cur_wdata),
        .rword_i (rword),
        .be_o    (be),
        .wlane_o (wlane),
        .rext_o  (rext)
    );

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_err   = err_q;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        io_act  = 1'b0;
`ifdef MMIO_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
        bus.cpu_done  = 1'b0;
        bus.cpu_busy  = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_be    = '0;
        bus.ram_wdata = '0;
        bus.io_sel    = '0;
        bus.io_we     = 1'b0;
        bus.io_reg    = '0;
        bus.io_wdata  = '0;

        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    we_d    = bus.cpu_we;
                    addr_d  = bus.cpu_addr;
                    f3_d    = bus.cpu_funct3;
                    wdata_d = bus.cpu_wdata;
                    if (bad) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else if (is_io) begin
                        io_act = 1'b1;
                        if (sel_rdy) begin
                            err_d   = 1'b0;
                            rdata_d = cur_we ? '0 : rext;
                            state_d = RESP;
                        end else begin
                            state_d = IO_WAIT;
                        end
                    end else begin
                        bus.ram_addr = cur_addr[RAM_AW+1:2];
                        if (cur_we) begin
                            bus.ram_be    = be;
                            bus.ram_wdata = wlane;
                            err_d         = 1'b0;
                            rdata_d       = '0;
                            state_d       = RESP;
                        end else begin
                            state_d = RAM_RD;
                        end
                    end
                end
            end
            RAM_RD: begin
                err_d   = 1'b0;
                rdata_d = rext;
                state_d = RESP;
            end
            IO_WAIT: begin
                io_act = 1'b1;
                if (sel_rdy) begin
                    err_d   = 1'b0;
                    rdata_d = cur_we ? '0 : rext;
                    state_d = RESP;
                end
`ifdef MMIO_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                bus.cpu_done = 1'b1;
                state_d      = IDLE;
            end
        endcase

        // IO stores always move the whole word; io_reg picks the register.
        if (io_act && rst) begin
            bus.io_sel   = NUM_IO'(1) << ch_idx;
            bus.io_we    = cur_we;
            bus.io_reg   = cur_addr[3:2];
            bus.io_wdata = cur_wdata;
        end

        bus.cpu_busy = rst && (acc || (state_q != IDLE));
        if (!rst) begin
            bus.cpu_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef MMIO_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule
